// File: rtl/ula_pkg.sv
// Shared encodings for the ula_acumulador accumulator: operation codes and FSM states.
package ula_pkg;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'b00,
    OP_INC     = 2'b01,
    OP_ADD_CIN = 2'b10,
    OP_CLR     = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/ula_acumulador.sv
// Accumulator/controller wrapped around an external combinational carry-in incrementer.
// Define ULA_ACC_SAT_EN to saturate INC/ADD_CIN at all-ones instead of wrapping.
module ula_acumulador
  import ula_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic             cin,
  output logic [WIDTH-1:0] add_a,
  output logic             add_cin,
  input  logic [WIDTH:0]   add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc_out,
  output logic             carry_out,
  output logic             zero_out
);

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] data_q;
  logic             cin_q;
  logic [WIDTH-1:0] acc;
  logic             carry;

  // The incrementer only sees a non-zero carry-in while an INC/ADD_CIN is executing.
  always_comb begin
    add_a   = acc;
    add_cin = 1'b0;
    if (state == ST_EXEC) begin
      if (op_q == OP_INC)          add_cin = 1'b1;
      else if (op_q == OP_ADD_CIN) add_cin = cin_q;
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign acc_out   = acc;
  assign carry_out = carry;
  assign zero_out  = (acc == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= ACC_INIT;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q   <= op_t'(op);
            data_q <= data_in;
            cin_q  <= cin;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_q)
            OP_LOAD: begin
              acc   <= data_q;
              carry <= 1'b0;
            end
            OP_INC, OP_ADD_CIN: begin
`ifdef ULA_ACC_SAT_EN
              if (add_sum[WIDTH]) begin
                acc   <= '1;
                carry <= 1'b1;
              end else begin
                acc   <= add_sum[WIDTH-1:0];
                carry <= 1'b0;
              end
`else
              acc   <= add_sum[WIDTH-1:0];
              carry <= add_sum[WIDTH];
`endif
            end
            default: begin
              acc   <= '0;
              carry <= 1'b0;
            end
          endcase
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          // Result and flags stay frozen until the consumer takes them.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_acumulador.sv
// Directed self-checking bench for ula_acumulador; the incrementer is modelled here as add_a + add_cin.
module tb_ula_acumulador;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] data_in;
  logic             cin;
  logic [WIDTH-1:0] add_a;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] acc_out;
  logic             carry_out;
  logic             zero_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign add_sum = {1'b0, add_a} + {{WIDTH{1'b0}}, add_cin};

  ula_acumulador #(.WIDTH(WIDTH), .ACC_INIT('0)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .data_in  (data_in),
    .cin      (cin),
    .add_a    (add_a),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out  (acc_out),
    .carry_out(carry_out),
    .zero_out (zero_out)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle and follows it through EXEC into DONE.
  task automatic applyStimulus(input string tag, input logic [1:0] op_v, input logic [WIDTH-1:0] d_v,
                               input logic cin_v, input logic exp_add_cin);
    checkOutput({tag, "_ready_idle"}, {7'd0, in_ready}, 8'd1);
    in_valid = 1'b1;
    op       = op_v;
    data_in  = d_v;
    cin      = cin_v;
    waitEdge();
    in_valid = 1'b0;
    op       = ~op_v;
    data_in  = ~d_v;
    cin      = ~cin_v;
    checkOutput({tag, "_exec_ready"}, {7'd0, in_ready}, 8'd0);
    checkOutput({tag, "_exec_valid"}, {7'd0, out_valid}, 8'd0);
    checkOutput({tag, "_exec_add_cin"}, {7'd0, add_cin}, {7'd0, exp_add_cin});
    waitEdge();
    checkOutput({tag, "_done_valid"}, {7'd0, out_valid}, 8'd1);
  endtask

  task automatic checkResult(input string tag, input logic [WIDTH-1:0] e_acc, input logic e_carry, input logic e_zero);
    checkOutput({tag, "_acc"}, {4'd0, acc_out}, {4'd0, e_acc});
    checkOutput({tag, "_carry"}, {7'd0, carry_out}, {7'd0, e_carry});
    checkOutput({tag, "_zero"}, {7'd0, zero_out}, {7'd0, e_zero});
  endtask

  task automatic takeResult(input string tag);
    out_ready = 1'b1;
    waitEdge();
    out_ready = 1'b0;
    checkOutput({tag, "_taken_valid"}, {7'd0, out_valid}, 8'd0);
    checkOutput({tag, "_taken_ready"}, {7'd0, in_ready}, 8'd1);
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 2'b00;
    data_in   = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    waitEdge();
    waitEdge();
    rst = 1'b0;
    waitEdge();

    // 1: reset state
    checkResult("reset", 4'h0, 1'b0, 1'b1);
    checkOutput("reset_valid", {7'd0, out_valid}, 8'd0);
    checkOutput("reset_ready", {7'd0, in_ready}, 8'd1);
    checkOutput("reset_add_a", {4'd0, add_a}, 8'd0);
    checkOutput("reset_add_cin", {7'd0, add_cin}, 8'd0);

    // 2: LOAD 9 then INC
    applyStimulus("load9", 2'b00, 4'h9, 1'b0, 1'b0);
    checkResult("load9", 4'h9, 1'b0, 1'b0);
    takeResult("load9");
    applyStimulus("inc9", 2'b01, 4'h0, 1'b0, 1'b1);
    checkResult("inc9", 4'hA, 1'b0, 1'b0);
    takeResult("inc9");

    // 3: LOAD F then INC (wrap or saturate)
    applyStimulus("loadF", 2'b00, 4'hF, 1'b0, 1'b0);
    checkResult("loadF", 4'hF, 1'b0, 1'b0);
    takeResult("loadF");
    applyStimulus("incF", 2'b01, 4'h0, 1'b0, 1'b1);
`ifdef ULA_ACC_SAT_EN
    checkResult("incF", 4'hF, 1'b1, 1'b0);
`else
    checkResult("incF", 4'h0, 1'b1, 1'b1);
`endif
    takeResult("incF");

    // 4: LOAD 5, ADD_CIN 0, ADD_CIN 1
    applyStimulus("load5", 2'b00, 4'h5, 1'b0, 1'b0);
    checkResult("load5", 4'h5, 1'b0, 1'b0);
    takeResult("load5");
    applyStimulus("addc0", 2'b10, 4'h0, 1'b0, 1'b0);
    checkResult("addc0", 4'h5, 1'b0, 1'b0);
    takeResult("addc0");
    applyStimulus("addc1", 2'b10, 4'h0, 1'b1, 1'b1);
    checkResult("addc1", 4'h6, 1'b0, 1'b0);
    takeResult("addc1");

    // CLR from a non-zero accumulator
    applyStimulus("clr", 2'b11, 4'hC, 1'b1, 1'b0);
    checkResult("clr", 4'h0, 1'b0, 1'b1);
    takeResult("clr");

    // 5: back-pressure in DONE with ignored request pulses
    applyStimulus("load7", 2'b00, 4'h7, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      op       = 2'b11;
      data_in  = 4'h2;
      waitEdge();
      checkOutput("hold_valid", {7'd0, out_valid}, 8'd1);
      checkOutput("hold_acc", {4'd0, acc_out}, 8'h07);
      checkOutput("hold_ready", {7'd0, in_ready}, 8'd0);
    end
    in_valid = 1'b0;
    takeResult("load7");
    waitEdge();
    checkOutput("hold_no_accept", {7'd0, out_valid}, 8'd0);
    checkOutput("hold_acc_after", {4'd0, acc_out}, 8'h07);

    // 6: reset during EXEC of INC from 3
    applyStimulus("load3", 2'b00, 4'h3, 1'b0, 1'b0);
    takeResult("load3");
    in_valid = 1'b1;
    op       = 2'b01;
    waitEdge();
    in_valid = 1'b0;
    checkOutput("rst_exec_ready", {7'd0, in_ready}, 8'd0);
    rst = 1'b1;
    waitEdge();
    rst = 1'b0;
    checkOutput("rst_ready", {7'd0, in_ready}, 8'd1);
    checkOutput("rst_valid", {7'd0, out_valid}, 8'd0);
    checkResult("rst", 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      waitEdge();
      checkOutput("rst_no_result", {7'd0, out_valid}, 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
